complex_gate_bist: RTL and testbench



---
 rtl/complex_gate_pkg.sv | 30 +++
 rtl/complex_gate_vec_rom.sv | 17 +
 rtl/complex_gate_bist.sv | 133 +++++++++++++
 tb/tb_complex_gate_bist.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/complex_gate_pkg.sv
// Shared definitions for the complex_gate self-test sequencer.
//   - FSM state encoding (3-bit)
//   - default widths / table size
//   - the test vector table and expected gate outputs
package complex_gate_pkg;

  localparam int WIDTH         = 16;
  localparam int NUM_VECTORS   = 8;
  localparam int SETTLE_CYCLES = 2;
  localparam int IDX_W         = $clog2(NUM_VECTORS);
  localparam int CNT_W         = $clog2(NUM_VECTORS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Entry i occupies bits [i*WIDTH +: WIDTH]; entry 0 is the rightmost word.
  localparam logic [NUM_VECTORS*WIDTH-1:0] VEC_TABLE = {
    16'hFFFF, 16'hAAAA, 16'h5826, 16'h00C3,
    16'hC300, 16'h00FF, 16'hFF00, 16'h0000
  };

  // Expected z for entry i is bit i.
  localparam logic [NUM_VECTORS-1:0] EXP_TABLE = 8'b1001_1110;

endpackage

// File: rtl/complex_gate_vec_rom.sv
// Combinational test-vector ROM for the complex_gate self-test.
// Ports:
//   idx_i  - table index
//   vec_o  - stimulus vector for complex_gate.x
//   exp_o  - expected complex_gate.z for that vector
module complex_gate_vec_rom
  import complex_gate_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] vec_o,
  output logic             exp_o
);

  assign vec_o = VEC_TABLE[idx_i*WIDTH +: WIDTH];
  assign exp_o = EXP_TABLE[idx_i];

endmodule

// File: rtl/complex_gate_bist.sv
// Hardware self-test sequencer for the complex_gate pattern detector.
// A start request walks the vector table: drive a vector, wait SETTLE_CYCLES,
// sample z_in against the expected bit, count mismatches and remember the
// first failing index. Results stay visible while done=1.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start             - level-sampled run request (ignored while busy)
//   x_out / z_in      - stimulus to and result from complex_gate
//   busy, done, pass  - run status; pass valid while done=1
//   err_count         - mismatching vectors in the last run
//   first_fail_idx    - index of the first mismatch
//   first_fail_valid  - at least one mismatch in the last run
module complex_gate_bist
  import complex_gate_pkg::*;
#(
  parameter int WIDTH         = complex_gate_pkg::WIDTH,
  parameter int NUM_VECTORS   = complex_gate_pkg::NUM_VECTORS,
  parameter int SETTLE_CYCLES = complex_gate_pkg::SETTLE_CYCLES,
  parameter int CNT_W         = complex_gate_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x_out,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SET_W-1:0] cnt_q;
  logic [WIDTH-1:0] x_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_q;
  logic [IDX_W-1:0] ffi_q;
  logic             ffv_q;

  logic [WIDTH-1:0] rom_vec;
  logic             rom_exp;
  logic             mismatch;
  logic [CNT_W-1:0] err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  complex_gate_vec_rom u_rom (
    .idx_i (idx_q),
    .vec_o (rom_vec),
    .exp_o (rom_exp)
  );

  assign mismatch = (z_in != rom_exp);
  // Error count as it will be after the current SAMPLE cycle; pass must see it.
  assign err_d    = mismatch ? sat_inc(err_q) : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      case (state_q)
        // DONE behaves like IDLE except that results stay on display.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          x_q     <= rom_vec;
          cnt_q   <= SET_W'(SETTLE_CYCLES - 1);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_SAMPLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !ffv_q) begin
            ffi_q <= idx_q;
            ffv_q <= 1'b1;
          end
          // done/pass are raised on the way into DONE so that a held start
          // restarts from DONE after exactly one cycle of done=1.
          if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_out            = x_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_complex_gate_bist.sv
// Self-checking bench for complex_gate_bist. A behavioural stand-in for the
// gate answers z_in from x_out via a table lookup, optionally corrupted by a
// per-vector fault mask or stuck-at mode; expected results are derived from
// the table and the fault pattern.
module tb_complex_gate_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x_out;
  logic        z_in;
  logic        busy, done, pass, first_fail_valid;
  logic [3:0]  err_count;
  logic [2:0]  first_fail_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tv [8] = '{16'h0000, 16'hFF00, 16'h00FF, 16'hC300,
                          16'h00C3, 16'h5826, 16'hAAAA, 16'hFFFF};
  logic [7:0]  te = 8'b1001_1110;

  // zmode 0: table answer XOR fault_mask, 1: stuck at 0, 2: stuck at 1
  int          zmode = 0;
  logic [7:0]  fault_mask = 8'h00;

  always #5 clk = ~clk;

  complex_gate_bist dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .x_out            (x_out),
    .z_in             (z_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  always_comb begin
    z_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (x_out == tv[i]) begin
        if (zmode == 1)      z_in = 1'b0;
        else if (zmode == 2) z_in = 1'b1;
        else                 z_in = te[i] ^ fault_mask[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one run from the current fault pattern.
  task automatic model(output int n_err, output int first);
    logic zi;
    n_err = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      zi = (zmode == 1) ? 1'b0 : (zmode == 2) ? 1'b1 : (te[i] ^ fault_mask[i]);
      if (zi != te[i]) begin
        n_err++;
        if (first < 0) first = i;
      end
    end
  endtask

  // One start pulse, then follow the run to done. poke>0 re-asserts start at
  // that cycle of the run (must be ignored while busy).
  task automatic run_check(input string tag, input int poke);
    int n_err, first, c, xbad, bbad;
    model(n_err, first);
    xbad = 0;
    bbad = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1;
    chk({tag, ".done_cleared"}, done, 0);
    while (!done && c < 60) begin
      if (c >= 2 && x_out != tv[(c - 2) / 4]) xbad++;
      if (!busy) bbad++;
      start = (c == poke);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, c, 33);
    chk({tag, ".x_seq_errors"}, xbad, 0);
    chk({tag, ".busy_gaps"}, bbad, 0);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".x_hold"}, x_out, 16'hFFFF);
    chk({tag, ".err_count"}, err_count, n_err);
    chk({tag, ".pass"}, pass, (n_err == 0));
    chk({tag, ".ff_valid"}, first_fail_valid, (first >= 0));
    chk({tag, ".ff_idx"}, first_fail_idx, (first >= 0) ? first : 0);
    repeat (3) @(negedge clk);
    chk({tag, ".done_holds"}, done, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".x_out"}, x_out, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err_count"}, err_count, 0);
    chk({tag, ".ff_idx"}, first_fail_idx, 0);
    chk({tag, ".ff_valid"}, first_fail_valid, 0);
  endtask

  initial begin
    int n_err, first, pulses, badpos, errbad, c;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    zmode = 0; fault_mask = 8'h00;
    run_check("good", 0);
    zmode = 1;
    run_check("stuck0", 0);
    zmode = 2;
    run_check("stuck1", 0);
    zmode = 0; fault_mask = 8'hFF;
    run_check("invert", 0);

    for (int k = 0; k < 6; k++) begin
      zmode = 0;
      fault_mask = 8'($urandom);
      run_check($sformatf("rand%0d", k), int'($urandom_range(2, 31)));
    end

    // Asynchronous reset in the middle of vector 3.
    zmode = 0; fault_mask = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.stays_idle", busy, 0);
    run_check("after_rst", 0);

    // start held high: back-to-back runs, one-cycle done every 33 cycles,
    // counters restarting each run.
    zmode = 0;
    fault_mask = 8'($urandom) | 8'h01;
    model(n_err, first);
    pulses = 0; badpos = 0; errbad = 0;
    @(negedge clk) start = 1'b1;
    for (c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (c % 33 != 0) badpos++;
        if (err_count != 4'(n_err)) errbad++;
      end
    end
    start = 1'b0;
    chk("held.pulses", pulses, 3);
    chk("held.pulse_pos", badpos, 0);
    chk("held.err_per_run", errbad, 0);
    c = 0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("held.final_done", done, 1);
    chk("held.final_err", err_count, n_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
